// File: rtl/dcache_mshr.sv
// D-cache MSHR: circular buffer of outstanding load refills and dirty writebacks; DCACHE_MSHR_MERGE_EN merges same-line load misses.
// Latency: allocation index is combinational, an entry drives the bus the cycle after allocation, refill broadcast is combinational on tag match.
// Backpressure: request ports stall when no entry is free (registered count only); the controller holds off by leaving Ctlr2proc_response at 0.
`ifndef XLEN
`define XLEN 32
`endif

module dcache_mshr #(
    parameter int DEPTH    = 8,
    parameter int LD_PORTS = 2,
    parameter int ST_PORTS = 3
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic [LD_PORTS-1:0]                  ld_req,
    input  logic [LD_PORTS-1:0][`XLEN-1:0]       ld_addr,
    output logic [LD_PORTS-1:0]                  ld_stall,
    output logic [LD_PORTS-1:0][$clog2(DEPTH)-1:0] ld_mshr_idx,
    input  logic [ST_PORTS-1:0]                  st_req,
    input  logic [ST_PORTS-1:0][`XLEN-1:0]       st_addr,
    input  logic [ST_PORTS-1:0][63:0]            st_data,
    output logic [ST_PORTS-1:0]                  st_stall,
    input  logic [3:0]                           Ctlr2proc_response,
    input  logic [3:0]                           Ctlr2proc_tag,
    input  logic [63:0]                          Ctlr2proc_data,
    output logic [1:0]                           dcache2ctlr_command,
    output logic [`XLEN-1:0]                     dcache2ctlr_addr,
    output logic [63:0]                          dcache2ctlr_data,
    output logic                                 bcast_valid,
    output logic [$clog2(DEPTH)-1:0]             bcast_idx,
    output logic [`XLEN-1:0]                     bcast_addr,
    output logic [63:0]                          bcast_line
);

    localparam int IDXW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'd0,
        BUS_LOAD  = 2'd1,
        BUS_STORE = 2'd2
    } bus_cmd_e;

    typedef struct packed {
        logic             valid;
        logic             issued;
        logic             done;
        bus_cmd_e         cmd;
        logic [3:0]       tag;
        logic [`XLEN-1:0] addr;
        logic [63:0]      data;
    } entry_t;

    entry_t            ent_q [DEPTH];
    logic [IDXW-1:0]   head_q, issue_q, tail_q;
    logic [IDXW:0]     count_q;

    logic [LD_PORTS-1:0]            ld_alloc;
    logic [LD_PORTS-1:0][IDXW-1:0]  ld_idx;
    logic [ST_PORTS-1:0]            st_alloc;
    logic [ST_PORTS-1:0][IDXW-1:0]  st_idx;
    logic [IDXW:0]                  n_alloc;
    logic                           cmd_vld, cmd_acc, retire;
    logic                           cpl_hit;
    logic [IDXW-1:0]                cpl_idx;
    logic                           addr_lsb_unused;

    function automatic logic [`XLEN-1:0] line_of(input logic [`XLEN-1:0] a);
        return {a[`XLEN-1:3], 3'b000};
    endfunction

    // Free space comes from the registered count, so a retire this cycle never feeds back into allocation.
    always_comb begin
        logic [IDXW:0]   free_left;
        logic [IDXW-1:0] next_slot;
        logic            merged;
        free_left = (IDXW+1)'(DEPTH) - count_q;
        next_slot = tail_q;
        n_alloc   = '0;
        ld_alloc  = '0;
        ld_idx    = '0;
        ld_stall  = '0;
        st_alloc  = '0;
        st_idx    = '0;
        st_stall  = '0;
        for (int p = LD_PORTS-1; p >= 0; p--) begin
            merged = 1'b0;
            if (!reset && ld_req[p]) begin
`ifdef DCACHE_MSHR_MERGE_EN
                for (int e = 0; e < DEPTH; e++) begin
                    if (!merged && ent_q[e].valid && !ent_q[e].done && ent_q[e].cmd == BUS_LOAD &&
                        ent_q[e].addr == line_of(ld_addr[p])) begin
                        merged    = 1'b1;
                        ld_idx[p] = IDXW'(e);
                    end
                end
                for (int j = LD_PORTS-1; j > p; j--) begin
                    if (!merged && ld_req[j] && !ld_stall[j] &&
                        line_of(ld_addr[j]) == line_of(ld_addr[p])) begin
                        merged    = 1'b1;
                        ld_idx[p] = ld_idx[j];
                    end
                end
`endif
                if (!merged) begin
                    if (free_left != '0) begin
                        ld_alloc[p] = 1'b1;
                        ld_idx[p]   = next_slot;
                        next_slot   = next_slot + IDXW'(1);
                        free_left   = free_left - (IDXW+1)'(1);
                        n_alloc     = n_alloc + (IDXW+1)'(1);
                    end else begin
                        ld_stall[p] = 1'b1;
                    end
                end
            end
        end
        for (int s = ST_PORTS-1; s >= 0; s--) begin
            if (!reset && st_req[s]) begin
                if (free_left != '0) begin
                    st_alloc[s] = 1'b1;
                    st_idx[s]   = next_slot;
                    next_slot   = next_slot + IDXW'(1);
                    free_left   = free_left - (IDXW+1)'(1);
                    n_alloc     = n_alloc + (IDXW+1)'(1);
                end else begin
                    st_stall[s] = 1'b1;
                end
            end
        end
    end

    assign ld_mshr_idx = ld_idx;

    always_comb begin
        addr_lsb_unused = 1'b0;
        for (int p = 0; p < LD_PORTS; p++) addr_lsb_unused = addr_lsb_unused ^ (^ld_addr[p][2:0]);
        for (int s = 0; s < ST_PORTS; s++) addr_lsb_unused = addr_lsb_unused ^ (^st_addr[s][2:0]);
    end

    // An entry still waiting at the issue pointer is valid and not yet issued; this also covers a full buffer.
    assign cmd_vld = !reset && ent_q[issue_q].valid && !ent_q[issue_q].issued;
    assign cmd_acc = cmd_vld && (Ctlr2proc_response != 4'd0);
    assign retire  = ent_q[head_q].valid && ent_q[head_q].done;

    assign dcache2ctlr_command = cmd_vld ? ent_q[issue_q].cmd  : BUS_NONE;
    assign dcache2ctlr_addr    = cmd_vld ? ent_q[issue_q].addr : '0;
    assign dcache2ctlr_data    = cmd_vld ? ent_q[issue_q].data : '0;

    always_comb begin
        cpl_hit = 1'b0;
        cpl_idx = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (!reset && !cpl_hit && Ctlr2proc_tag != 4'd0 && ent_q[e].valid && ent_q[e].issued &&
                !ent_q[e].done && ent_q[e].cmd == BUS_LOAD && ent_q[e].tag == Ctlr2proc_tag) begin
                cpl_hit = 1'b1;
                cpl_idx = IDXW'(e);
            end
        end
    end

    assign bcast_valid = cpl_hit;
    assign bcast_idx   = cpl_idx;
    assign bcast_addr  = cpl_hit ? ent_q[cpl_idx].addr : '0;
    assign bcast_line  = cpl_hit ? Ctlr2proc_data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
            head_q  <= '0;
            issue_q <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (retire) begin
                ent_q[head_q] <= '0;
                head_q        <= head_q + IDXW'(1);
            end
            if (cmd_acc) begin
                ent_q[issue_q].tag    <= Ctlr2proc_response;
                ent_q[issue_q].issued <= 1'b1;
                if (ent_q[issue_q].cmd == BUS_STORE) ent_q[issue_q].done <= 1'b1;
                issue_q <= issue_q + IDXW'(1);
            end
            if (cpl_hit) ent_q[cpl_idx].done <= 1'b1;
            for (int p = 0; p < LD_PORTS; p++) begin
                if (ld_alloc[p]) begin
                    ent_q[ld_idx[p]] <= '{valid: 1'b1, issued: 1'b0, done: 1'b0, cmd: BUS_LOAD,
                                          tag: 4'd0, addr: line_of(ld_addr[p]), data: 64'd0};
                end
            end
            for (int s = 0; s < ST_PORTS; s++) begin
                if (st_alloc[s]) begin
                    ent_q[st_idx[s]] <= '{valid: 1'b1, issued: 1'b0, done: 1'b0, cmd: BUS_STORE,
                                          tag: 4'd0, addr: line_of(st_addr[s]), data: st_data[s]};
                end
            end
            tail_q  <= tail_q + n_alloc[IDXW-1:0];
            count_q <= count_q + n_alloc - (IDXW+1)'(retire);
        end
    end

endmodule
